// File: rtl/mmx_counter_pkg.sv
// Shared types and default lane steps for the mmx_counter packed-SIMD counter.
package mmx_counter_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0]         lane_t;
  typedef lane_t [NUM_LANES-1:0]     lanes_t;
  typedef logic [1:0]                phase_t;

  localparam lane_t STEP0_DEFAULT = 8'd1;
  localparam lane_t STEP1_DEFAULT = 8'd3;
  localparam lane_t STEP2_DEFAULT = 8'd5;
  localparam lane_t STEP3_DEFAULT = 8'd7;

endpackage

// File: rtl/mmx_packed_add.sv
// Combinational 4-lane packed byte adder; carries never cross lane boundaries.
// Build option MMX_SATURATE_EN selects unsigned saturating add instead of wrap.
module mmx_packed_add
  import mmx_counter_pkg::*;
(
  input  lanes_t a,
  input  lanes_t b,
  output lanes_t sum
);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
`ifdef MMX_SATURATE_EN
    logic [LANE_W:0] wide;
    assign wide    = {1'b0, a[gi]} + {1'b0, b[gi]};
    // A carry out of the lane clamps to all-ones, like PADDUSB.
    assign sum[gi] = wide[LANE_W] ? {LANE_W{1'b1}} : wide[LANE_W-1:0];
`else
    assign sum[gi] = a[gi] + b[gi];
`endif
  end

endmodule

// File: rtl/mmx_counter.sv
// Packed-SIMD counter on an 8-in/8-out pad ring: four byte lanes, shown round-robin.
// Optional build macro MMX_SATURATE_EN switches lanes from wrap to saturating add.
module mmx_counter
  import mmx_counter_pkg::*;
#(
  parameter lane_t STEP0 = STEP0_DEFAULT,
  parameter lane_t STEP1 = STEP1_DEFAULT,
  parameter lane_t STEP2 = STEP2_DEFAULT,
  parameter lane_t STEP3 = STEP3_DEFAULT
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst;
  logic [5:0] pad_unused;

  assign clk        = io_in[0];
  assign rst        = io_in[1];
  assign pad_unused = io_in[7:2];

  lanes_t lanes_reg;
  lanes_t lanes_next;
  lanes_t steps;
  phase_t ph_reg;
  lane_t  out_q;

  assign steps = {STEP3, STEP2, STEP1, STEP0};

  mmx_packed_add u_add (
    .a   (lanes_reg),
    .b   (steps),
    .sum (lanes_next)
  );

  // Output shows the pre-edge lane value, giving one cycle of latency to the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_reg <= '0;
      ph_reg    <= '0;
      out_q     <= '0;
    end else begin
      out_q     <= lanes_reg[ph_reg];
      ph_reg    <= ph_reg + 2'd1;
      lanes_reg <= lanes_next;
    end
  end

  assign io_out = out_q;

endmodule

// File: tb/tb_mmx_counter.sv
// Scoreboard bench for mmx_counter: stimulus pushes expected io_out per edge, monitor checks.
// Expectations follow MMX_SATURATE_EN when the bench is built with that macro.
module tb_mmx_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] junk = '0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {junk, rst, clk};

  mmx_counter dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         n;
    string      tag;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  int         step_tbl[4] = '{1, 3, 5, 7};
  logic [7:0] first8[8]   = '{8'h00, 8'h03, 8'h0A, 8'h15, 8'h04, 8'h0F, 8'h1E, 8'h31};

  // Closed form: after edge n, io_out = lane k's value after m = n-1 updates.
  function automatic logic [7:0] closed_form(int n);
    int m = n - 1;
    int k = m % 4;
    int v = m * step_tbl[k];
`ifdef MMX_SATURATE_EN
    if (v > 255) v = 255;
`else
    v = v % 256;
`endif
    return v[7:0];
  endfunction

  // Hand-computed values at the called-out edges; closed form elsewhere.
  function automatic logic [7:0] pick(int n, output string tag);
    tag = "seq";
    if (n <= 8) begin tag = "first8"; return first8[n-1]; end
`ifdef MMX_SATURATE_EN
    if (n == 40)  begin tag = "lane3_e40";  return 8'hFF; end
    if (n == 253) begin tag = "lane0_e253"; return 8'hFC; end
    if (n == 257) begin tag = "lane0_e257"; return 8'hFF; end
    if (n == 258) begin tag = "lane1_e258"; return 8'hFF; end
`else
    if (n == 40)  begin tag = "lane3_e40";  return 8'h11; end
    if (n == 253) begin tag = "lane0_e253"; return 8'hFC; end
    if (n == 257) begin tag = "lane0_e257"; return 8'h00; end
    if (n == 258) begin tag = "lane1_e258"; return 8'h03; end
`endif
    return closed_form(n);
  endfunction

  task automatic reset_edges(int cnt, string tag);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      rst  = 1'b1;
      junk = 6'($urandom);
      @(posedge clk);
      exp_q.push_back('{exp: 8'h00, n: 0, tag: tag});
    end
  endtask

  task automatic run_edges(int cnt, bit toggle_junk);
    item_t it;
    for (int n = 1; n <= cnt; n++) begin
      @(negedge clk);
      rst  = 1'b0;
      junk = toggle_junk ? 6'($urandom) : 6'd0;
      @(posedge clk);
      it.n   = n;
      it.exp = pick(n, it.tag);
      exp_q.push_back(it);
    end
  endtask

  // Monitor: io_out is presented every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      it = exp_q.pop_front();
      checks++;
      if (io_out !== it.exp) begin
        errors++;
        $display("FAIL %s n=%0d io_out=0x%02h expected=0x%02h", it.tag, it.n, io_out, it.exp);
      end else begin
        $display("ok   %s n=%0d io_out=0x%02h", it.tag, it.n, io_out);
      end
    end
  end

  initial begin
    reset_edges(3, "reset");
    run_edges(300, 1'b1);

    reset_edges(1, "reset2");
    run_edges(50, 1'b0);
    reset_edges(1, "midrun_rst");
    run_edges(8, 1'b0);

`ifdef MMX_SATURATE_EN
    reset_edges(2, "reset3");
    run_edges(1100, 1'b1);
`endif

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
